console_driver: RTL and testbench

Front-panel sequencer that drives the microcoded computer's console inputs (`SWA`, `SWB`, `input_data`, `pc_clr`) and captures `led_out`. It loads program words into RAM, reads RAM back, and starts execution. It paces itself by watching the computer's micro-address and execute phase. It sits between a host-side stream interface and the computer top level.

---
 rtl/console_driver.sv | 125 ++++++++++++
 tb/tb_console_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/console_driver.sv
// console_driver: front-panel sequencer that loads/reads computer RAM and starts runs via SWA/SWB/input_data/pc_clr.
// Define CONSOLE_TIMEOUT_EN to enable the per-word watchdog.
module console_driver #(
   parameter int         DATA_WIDTH = 16,
   parameter logic [7:0] IDLE_UADDR = 8'h00,
   parameter int         TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic [DATA_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic [7:0]            uaddr_in,
   input  logic                  exec_phase,
   input  logic [DATA_WIDTH-1:0] led_in,
   output logic                  SWA,
   output logic                  SWB,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  pc_clr,
   output logic                  busy,
   output logic                  error
);
   typedef enum logic [2:0] {IDLE, ADDR, WFETCH, WWAIT, RWAIT, RUN, DONE} state_t;
`ifdef CONSOLE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, rdat_q, rdat_d;
   logic                  left_q, left_d, rv_q, rv_d, err_q, err_d, run_q, run_d;
   logic [15:0]           tmo_q, tmo_d;
   logic                  accept, consumed, restart, waiting, timeout;
   assign accept   = state_q == IDLE && cmd_valid;
   assign consumed = exec_phase && uaddr_in == IDLE_UADDR && left_q;
   // every word starts a fresh wait: entering ADDR, WWAIT or RWAIT (RWAIT re-entered after each consumption)
   assign restart  = accept || (state_q == WFETCH && wr_valid) || consumed;
   assign waiting  = state_q inside {ADDR, WWAIT, RWAIT};
   assign timeout  = TMO_EN && waiting && !consumed && tmo_q == 16'(TIMEOUT - 1);
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rdat_d  = rdat_q;
      rv_d    = 1'b0;
      err_d   = err_q;
      run_d   = 1'b0;
      left_d  = restart ? 1'b0 : (exec_phase && uaddr_in != IDLE_UADDR) ? 1'b1 : left_q;
      tmo_d   = restart ? '0 : waiting ? tmo_q + 16'd1 : tmo_q;
      unique case (state_q)
         IDLE: if (cmd_valid) begin
            mode_d  = cmd_mode;
            cnt_d   = cmd_len;
            err_d   = cmd_mode == 2'b11;
            dout_d  = cmd_mode == 2'b11 ? dout_q : cmd_addr;
            state_d = cmd_mode == 2'b11 ? DONE : cmd_mode == 2'b00 ? RUN : ADDR;
         end
         ADDR: if (consumed) state_d = cnt_q == 8'd0 ? DONE : mode_q == 2'b01 ? WFETCH : RWAIT;
         WFETCH: if (wr_valid) begin
            dout_d  = wr_data;
            state_d = WWAIT;
         end
         WWAIT, RWAIT: if (consumed) begin
            cnt_d   = cnt_q - 8'd1;
            rv_d    = state_q == RWAIT;
            rdat_d  = state_q == RWAIT ? led_in : rdat_q;
            state_d = cnt_q == 8'd1 ? DONE : state_q == WWAIT ? WFETCH : RWAIT;
         end
         RUN: begin
            run_d   = 1'b1;
            state_d = run_q ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         err_d   = 1'b1;
         state_d = DONE;
      end
      if (state_d == DONE) dout_d = '0;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         mode_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         rdat_q  <= '0;
         left_q  <= 1'b0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rdat_q  <= rdat_d;
         left_q  <= left_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
         run_q   <= run_d;
         tmo_q   <= tmo_d;
      end
   end
   assign cmd_ready  = state_q == IDLE;
   assign wr_ready   = state_q == WFETCH;
   assign rd_valid   = rv_q;
   assign rd_data    = rdat_q;
   assign {SWB, SWA} = waiting || state_q == WFETCH ? mode_q : 2'b00;
   assign data_out   = dout_q;
   assign pc_clr     = state_q == RUN;
   assign busy       = state_q != IDLE;
   assign error      = err_q;
endmodule

// File: tb/tb_console_driver.sv
// tb_console_driver: table-driven console command vectors against a pseudo-computer that returns to micro-address 0 every 6 clk.
module tb_console_driver;
   logic        clk = 1'b0, clr = 1'b1, cmd_valid = 1'b0, wr_valid = 1'b0, exec_phase = 1'b0;
   logic [1:0]  cmd_mode = 2'b00;
   logic [15:0] cmd_addr = '0, wr_data = '0, led_in = '0;
   logic [7:0]  cmd_len = '0, uaddr_in = '0;
   logic        cmd_ready, wr_ready, rd_valid, SWA, SWB, pc_clr, busy, error;
   logic [15:0] rd_data, data_out;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] addr;
      logic [7:0]  len;
      bit          poke;
      logic [47:0] w;
      logic [31:0] r;
      int          n_wr, n_rd, n_pc, n_dout;
      logic [63:0] d;
      logic [1:0]  sw;
      logic        err;
      int          busy_cyc;
   } vec_t;

   int          vec_n = 0, miss_n = 0;
   int          ph = 0, wr_n = 0, rd_n = 0, busy_n = 0, pc_n = 0;
   bit          stuck = 1'b0;
   logic [47:0] wtab = '0;
   logic [31:0] rtab = '0;
   logic [1:0]  sw_seen = 2'b00;
   logic [15:0] last_dout = '0;
   logic [15:0] dq[$], rq[$];

   console_driver #(.DATA_WIDTH(16), .IDLE_UADDR(8'h00), .TIMEOUT(20)) dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .uaddr_in(uaddr_in), .exec_phase(exec_phase), .led_in(led_in),
      .SWA(SWA), .SWB(SWB), .data_out(data_out), .pc_clr(pc_clr), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [1:0] m, input logic [15:0] a, input logic [7:0] l, input bit pk,
                               input logic [47:0] w, input logic [31:0] r, input int nwr, input int nrd,
                               input int npc, input int nd, input logic [63:0] d, input logic [1:0] sw,
                               input logic err, input int bc);
      vec_t v;
      v.mode = m; v.addr = a; v.len = l; v.poke = pk; v.w = w; v.r = r;
      v.n_wr = nwr; v.n_rd = nrd; v.n_pc = npc; v.n_dout = nd; v.d = d; v.sw = sw; v.err = err; v.busy_cyc = bc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         miss_n++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // computer model and host stimulus change on the falling edge; DUT outputs are sampled 1 ns later
   task automatic tick();
      @(negedge clk);
      ph         = ph == 5 ? 0 : ph + 1;
      uaddr_in   = stuck ? 8'h05 : ph == 0 ? 8'h00 : 8'h10 + 8'(ph);
      exec_phase = stuck || ph % 2 == 0;
      led_in     = rd_n < 2 ? rtab[16*rd_n +: 16] : 16'h0000;
      wr_valid   = wr_n < 3;
      wr_data    = wr_n < 3 ? wtab[16*wr_n +: 16] : 16'h0000;
      #1;
      if (busy) begin
         busy_n++;
         if ({SWB, SWA} != 2'b00) sw_seen = {SWB, SWA};
      end
      if (data_out != last_dout) begin
         if (data_out != 16'h0000) dq.push_back(data_out);
         last_dout = data_out;
      end
      if (wr_ready && wr_valid) wr_n++;
      if (rd_valid) begin
         rq.push_back(rd_data);
         rd_n++;
      end
      if (pc_clr) pc_n++;
   endtask

   task automatic start(input logic [1:0] m, input logic [15:0] a, input logic [7:0] l);
      wr_n = 0; rd_n = 0; busy_n = 0; pc_n = 0; sw_seen = 2'b00;
      dq.delete();
      rq.delete();
      cmd_valid = 1'b1; cmd_mode = m; cmd_addr = a; cmd_len = l;
      tick();
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 2000 && busy; t++) tick();
      if (busy) begin
         vec_n++;
         miss_n++;
         $display("FAIL idle_wait: busy=%0b required 0 within 2000 clk", busy);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_cmd_ready"}, cmd_ready, 1);
      chk({p, "_wr_ready"}, wr_ready, 0);
      chk({p, "_rd_valid"}, rd_valid, 0);
      chk({p, "_rd_data"}, rd_data, 0);
      chk({p, "_sw"}, {SWB, SWA}, 0);
      chk({p, "_data_out"}, data_out, 0);
      chk({p, "_pc_clr"}, pc_clr, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_error"}, error, 0);
   endtask

   initial begin
      vec_t tab[6];
      tab[0] = mk(2'b01, 16'h0010, 8'd3, 1'b1, {16'h3333, 16'h2222, 16'h1111}, 32'h0, 3, 0, 0, 4,
                  {16'h3333, 16'h2222, 16'h1111, 16'h0010}, 2'b01, 1'b0, -1);
      tab[1] = mk(2'b10, 16'h0020, 8'd2, 1'b0, 48'h0, {16'h1234, 16'hABCD}, 0, 2, 0, 1,
                  {48'h0, 16'h0020}, 2'b10, 1'b0, -1);
      tab[2] = mk(2'b00, 16'h0000, 8'd0, 1'b0, 48'h0, 32'h0, 0, 0, 2, 0, 64'h0, 2'b00, 1'b0, 3);
      tab[3] = mk(2'b01, 16'h0040, 8'd0, 1'b0, {16'h3333, 16'h2222, 16'h1111}, 32'h0, 0, 0, 0, 1,
                  {48'h0, 16'h0040}, 2'b01, 1'b0, -1);
      tab[4] = mk(2'b11, 16'h7777, 8'd1, 1'b0, 48'h0, 32'h0, 0, 0, 0, 0, 64'h0, 2'b00, 1'b1, 1);
      tab[5] = mk(2'b10, 16'h0030, 8'd1, 1'b0, 48'h0, {16'h0000, 16'h5A5A}, 0, 1, 0, 1,
                  {48'h0, 16'h0030}, 2'b10, 1'b0, -1);
      tick();
      tick();
      chk_reset("reset");
      clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wtab = tab[i].w;
         rtab = tab[i].r;
         start(tab[i].mode, tab[i].addr, tab[i].len);
         if (tab[i].poke) begin
            cmd_mode = 2'b00;
            for (int k = 0; k < 3; k++) tick();
         end
         cmd_valid = 1'b0;
         wait_idle();
         chk($sformatf("v%0d_n_wr", i), wr_n, tab[i].n_wr);
         chk($sformatf("v%0d_n_rd", i), rd_n, tab[i].n_rd);
         for (int k = 0; k < tab[i].n_rd; k++)
            chk($sformatf("v%0d_rd%0d", i, k), k < rq.size() ? {16'h0, rq[k]} : 32'hFFFF_FFFF, {16'h0, tab[i].r[16*k +: 16]});
         chk($sformatf("v%0d_sw", i), sw_seen, tab[i].sw);
         chk($sformatf("v%0d_pc_clr_cycles", i), pc_n, tab[i].n_pc);
         chk($sformatf("v%0d_n_dout", i), dq.size(), tab[i].n_dout);
         for (int k = 0; k < tab[i].n_dout; k++)
            chk($sformatf("v%0d_dout%0d", i, k), k < dq.size() ? {16'h0, dq[k]} : 32'hFFFF_FFFF, {16'h0, tab[i].d[16*k +: 16]});
         chk($sformatf("v%0d_error", i), error, tab[i].err);
         if (tab[i].busy_cyc >= 0) chk($sformatf("v%0d_busy_cycles", i), busy_n, tab[i].busy_cyc);
         chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
      end
`ifdef CONSOLE_TIMEOUT_EN
      stuck = 1'b1;
      wtab = '0;
      rtab = '0;
      start(2'b01, 16'h0050, 8'd1);
      cmd_valid = 1'b0;
      wait_idle();
      chk("timeout_busy_cycles", busy_n, 21);
      chk("timeout_error", error, 1);
      chk("timeout_sw", {SWB, SWA}, 0);
      chk("timeout_n_wr", wr_n, 0);
      stuck = 1'b0;
`endif
      start(2'b11, 16'h0000, 8'd0);
      cmd_valid = 1'b0;
      wait_idle();
      chk("mode11_error_sticky", error, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_error", error, 0);
      wtab = {16'hC3C3, 16'hB2B2, 16'hA1A1};
      rtab = '0;
      start(2'b01, 16'h0060, 8'd3);
      cmd_valid = 1'b0;
      for (int t = 0; t < 200 && wr_n == 0; t++) tick();
      tick();
      chk("wwait_busy", busy, 1);
      chk("wwait_wr_ready", wr_ready, 0);
      chk("wwait_data_out", data_out, 16'hA1A1);
      chk("wwait_sw", {SWB, SWA}, 2'b01);
      clr = 1'b1;
      tick();
      chk_reset("clr_wwait");
      clr = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end
endmodule
